// File: rtl/queen_column_encoder_if.sv
// Request/result bundle for the queen column encoder: scan request in, scan result out.
interface queen_column_encoder_if #(
  parameter int WIDTH = 3
);
  localparam int N = 1 << WIDTH;

  logic             start;
  logic [N-1:0]     mask;
  logic [WIDTH-1:0] from;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] binary;

  modport master (
    output start, mask, from,
    input  busy, done, found, binary
  );

  modport slave (
    input  start, mask, from,
    output busy, done, found, binary
  );
endinterface

// File: rtl/queen_column_encoder.sv
// Sequential priority encoder: scans a latched free-column mask upward from a start
// column, one column per clock, and reports the first free column or that none exists.
module queen_column_encoder #(
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  queen_column_encoder_if.slave  bus
);
  localparam int N = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST_COL = WIDTH'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [N-1:0]     mask_q,   mask_d;
  logic [WIDTH-1:0] idx_q,    idx_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             found_q,  found_d;
  logic [WIDTH-1:0] binary_q, binary_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d  = state_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    binary_d = binary_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          mask_d  = bus.mask;
          idx_d   = bus.from;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (mask_q[idx_q]) begin
          binary_d = idx_q;
          found_d  = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (idx_q == LAST_COL) begin
          // Ran off the top column without a hit; no wrap-around to lower columns.
          binary_d = '0;
          found_d  = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      // NOTE: the latched mask is a plain register, not a memory, so resetting it is cheap and keeps it deterministic.
      mask_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      binary_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      binary_q <= binary_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.binary = binary_q;
endmodule

// File: tb/tb_queen_column_encoder.sv
// Self-checking bench for queen_column_encoder: vector table plus hand-written
// handshake/reset sequences, results checked through an expected-result queue.
module tb_queen_column_encoder;
  localparam int WIDTH = 3;
  localparam int N     = 1 << WIDTH;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  bit   mon_en;

  queen_column_encoder_if #(.WIDTH(WIDTH)) bus ();

  queen_column_encoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]     mask;
    logic [WIDTH-1:0] from;
    logic             found;
    logic [WIDTH-1:0] binary;
    int               lat;
  } vec_t;

  typedef struct {
    logic             found;
    logic [WIDTH-1:0] binary;
    int               lat;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result monitor: pops the scoreboard on each done pulse and checks handshake invariants.
  logic             last_found;
  logic [WIDTH-1:0] last_bin;
  int               busy_cnt;
  bit               prev_done;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        busy_cnt   = 0;
        last_found = 1'b0;
        last_bin   = '0;
        prev_done  = 1'b0;
      end else begin
        exp_t e;
        check(!(bus.busy === 1'b1 && bus.done === 1'b1), "busy_done_exclusive",
              {30'd0, bus.busy, bus.done}, 32'd0);
        if (bus.busy === 1'b1) begin
          busy_cnt++;
          check(bus.found === last_found && bus.binary === last_bin, "result_held_while_busy",
                {28'd0, bus.found, bus.binary}, {28'd0, last_found, last_bin});
        end
        if (bus.done === 1'b1) begin
          check(!prev_done, "done_one_cycle", 32'd1, 32'd0);
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check(bus.found === e.found, "found", {31'd0, bus.found}, {31'd0, e.found});
            check(bus.binary === e.binary, "binary", {29'd0, bus.binary}, {29'd0, e.binary});
            check(cyc == e.cyc, "done_latency_edge", cyc, e.cyc);
            check(busy_cnt == e.lat, "busy_cycles", busy_cnt, e.lat);
          end
          last_found = bus.found;
          last_bin   = bus.binary;
          busy_cnt   = 0;
        end
        prev_done = (bus.done === 1'b1);
      end
    end
  end

  // Drive a start request at the current point and queue its expected result.
  task automatic drive_start(input logic [N-1:0] m, input logic [WIDTH-1:0] f,
                             input logic ef, input logic [WIDTH-1:0] eb, input int el);
    bus.start = 1'b1;
    bus.mask  = m;
    bus.from  = f;
    sb.push_back('{found: ef, binary: eb, lat: el, cyc: cyc + 1 + el});
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "scan_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check(bus.busy === 1'b0 && bus.done === 1'b0 && bus.found === 1'b0 && bus.binary === '0,
          name, {27'd0, bus.busy, bus.done, bus.found, bus.binary}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.mask  = '0;
    bus.from  = '0;

    vecs[0] = '{mask: 8'b0010_0100, from: 3'd0, found: 1'b1, binary: 3'd2, lat: 3};
    vecs[1] = '{mask: 8'b0010_0100, from: 3'd3, found: 1'b1, binary: 3'd5, lat: 3};
    vecs[2] = '{mask: 8'h0F,        from: 3'd4, found: 1'b0, binary: 3'd0, lat: 4};
    vecs[3] = '{mask: 8'h00,        from: 3'd0, found: 1'b0, binary: 3'd0, lat: 8};
    vecs[4] = '{mask: 8'h80,        from: 3'd7, found: 1'b1, binary: 3'd7, lat: 1};
    vecs[5] = '{mask: 8'h01,        from: 3'd0, found: 1'b1, binary: 3'd0, lat: 1};
    vecs[6] = '{mask: 8'hFF,        from: 3'd5, found: 1'b1, binary: 3'd5, lat: 1};
    vecs[7] = '{mask: 8'h40,        from: 3'd1, found: 1'b1, binary: 3'd6, lat: 6};
    vecs[8] = '{mask: 8'h03,        from: 3'd2, found: 1'b0, binary: 3'd0, lat: 6};
    vecs[9] = '{mask: 8'h80,        from: 3'd0, found: 1'b1, binary: 3'd7, lat: 8};

    // Asynchronous reset mid-cycle, before any clock edge has occurred.
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outputs_zero("reset_idle");
    end

    // Table-driven scans.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_start(vecs[i].mask, vecs[i].from, vecs[i].found, vecs[i].binary, vecs[i].lat);
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle(N + 4);
      repeat (2) @(negedge clk);
      check(bus.found === vecs[i].found && bus.binary === vecs[i].binary, "result_held_idle",
            {28'd0, bus.found, bus.binary}, {28'd0, vecs[i].found, vecs[i].binary});
    end

    // Inputs changed while busy must not disturb the latched scan.
    @(negedge clk);
    drive_start(8'b0010_0100, 3'd3, 1'b1, 3'd5, 3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mask  = 8'h00;
    bus.from  = 3'd0;
    wait_idle(N + 4);

    // A start pulse in the middle of a long scan is ignored: one done, at the original latency.
    @(negedge clk);
    drive_start(8'h80, 3'd0, 1'b1, 3'd7, 8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.mask  = 8'h01;
    bus.from  = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(N + 4);
    repeat (4) @(negedge clk);

    // Start held through a scan and its done cycle launches the next scan with no dead cycle.
    @(negedge clk);
    drive_start(8'h04, 3'd0, 1'b1, 3'd2, 3);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < N + 4; i++) begin
        @(negedge clk);
        #1;
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          drive_start(8'h08, 3'd3, 1'b1, 3'd3, 1);
          break;
        end
      end
      check(seen, "b2b_first_done", {31'd0, seen}, 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(N + 4);

    // Reset in the middle of a scan aborts it with no done pulse.
    @(negedge clk);
    drive_start(8'h80, 3'd0, 1'b1, 3'd7, 8);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check_outputs_zero("reset_mid_scan");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check_outputs_zero("after_abort");
    end

    check(sb.size() == 0, "scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
